// File: rtl/dp_mem_pkg.sv
// Shared types and defaults for the dual-port memory arbiter slice.
package dp_mem_pkg;

    localparam int DEF_DATA_SIZE  = 32;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int NUM_CLIENTS    = 2;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_WR,
        CMD_RD,
        CMD_WRRD,
        CMD_CLR
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        CLR
    } state_e;

    function automatic logic cmd_writes(input cmd_e c);
        return (c == CMD_WR) || (c == CMD_WRRD);
    endfunction

    function automatic logic cmd_reads(input cmd_e c);
        return (c == CMD_RD) || (c == CMD_WRRD);
    endfunction

endpackage

// File: rtl/dp_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer remembers the last sole-granted client.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic [1:0] gnt
);

    logic ptr_reg;  // 1 = B was granted last, so A wins the next tie

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= 1'b1;
        end else if (upd_en && (gnt != 2'b00)) begin
            ptr_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/dp_mem_arbiter.sv
// Two-client arbiter/sequencer for dp_memory: clear, write/read merge,
// round-robin otherwise, and read-data routing back to the issuing client.
module dp_mem_arbiter
    import dp_mem_pkg::*;
#(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_SIZE-1:0]  wdata_a,
    input  logic [DATA_SIZE-1:0]  wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_SIZE-1:0]  rdata_a,
    output logic [DATA_SIZE-1:0]  rdata_b,
    input  logic                  clr_req,
    output logic                  clr_done,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic [DATA_SIZE-1:0]  mem_w_data,
    input  logic [DATA_SIZE-1:0]  mem_r_data,
    input  logic                  mem_ready,
    output logic                  err
);

    logic [1:0]            req_v, elig, pick, gnt_next, rd_next;
    logic [1:0]            gnt_reg, rd_issue_reg, rd_pend_reg, rvalid_v;
    logic [DATA_SIZE-1:0]  rdata_v [NUM_CLIENTS];
    logic                  clr_elig, merge, upd_en;
    logic                  sel, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr, w_addr_next, r_addr_next;
    logic [DATA_SIZE-1:0]  sel_wdata, w_data_next;
    cmd_e                  cmd_next;
    state_e                state_reg;
    logic                  mem_valid_reg, mem_we_reg, mem_re_reg;
    logic [ADDR_WIDTH-1:0] mem_w_addr_reg, mem_r_addr_reg;
    logic [DATA_SIZE-1:0]  mem_w_data_reg;
    logic                  clr_done_reg, err_reg;

    assign req_v = {req_b, req_a};

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            assign elig[gi]     = req_v[gi] & ~gnt_reg[gi];
            assign rvalid_v[gi] = rd_pend_reg[gi] & mem_ready;
            assign rdata_v[gi]  = rvalid_v[gi] ? mem_r_data : '0;
        end
    endgenerate

    // A clear is a handshake too: it stays ineligible while on the bus and while done is shown.
    assign clr_elig = clr_req & ~clr_done_reg & (state_reg != CLR);
    assign merge    = (&elig) & (we_a ^ we_b) & (addr_a != addr_b);
    assign upd_en   = ~clr_elig & ~merge;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (elig),
        .upd_en (upd_en),
        .gnt    (pick)
    );

    assign sel       = pick[1];
    assign sel_we    = sel ? we_b    : we_a;
    assign sel_addr  = sel ? addr_b  : addr_a;
    assign sel_wdata = sel ? wdata_b : wdata_a;

    always_comb begin
        cmd_next    = CMD_NONE;
        gnt_next    = 2'b00;
        rd_next     = 2'b00;
        w_addr_next = '0;
        r_addr_next = '0;
        w_data_next = '0;
        if (clr_elig) begin
            cmd_next = CMD_CLR;
        end else if (merge) begin
            cmd_next    = CMD_WRRD;
            gnt_next    = 2'b11;
            w_addr_next = we_a ? addr_a  : addr_b;
            w_data_next = we_a ? wdata_a : wdata_b;
            r_addr_next = we_a ? addr_b  : addr_a;
            rd_next     = we_a ? 2'b10   : 2'b01;
        end else if (pick != 2'b00) begin
            gnt_next = pick;
            if (sel_we) begin
                cmd_next    = CMD_WR;
                w_addr_next = sel_addr;
                w_data_next = sel_wdata;
            end else begin
                cmd_next    = CMD_RD;
                r_addr_next = sel_addr;
                rd_next     = pick;
            end
        end
    end

    // Read pending follows the read command by one edge, lining up with mem_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            mem_valid_reg  <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_re_reg     <= 1'b0;
            mem_w_addr_reg <= '0;
            mem_r_addr_reg <= '0;
            mem_w_data_reg <= '0;
            gnt_reg        <= 2'b00;
            rd_issue_reg   <= 2'b00;
            rd_pend_reg    <= 2'b00;
            clr_done_reg   <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            case (cmd_next)
                CMD_CLR:  state_reg <= CLR;
                CMD_NONE: state_reg <= IDLE;
                default:  state_reg <= CMD;
            endcase
            mem_valid_reg  <= (cmd_next != CMD_NONE);
            mem_we_reg     <= cmd_writes(cmd_next);
            mem_re_reg     <= cmd_reads(cmd_next);
            mem_w_addr_reg <= w_addr_next;
            mem_r_addr_reg <= r_addr_next;
            mem_w_data_reg <= w_data_next;
            gnt_reg        <= gnt_next;
            rd_issue_reg   <= rd_next;
            rd_pend_reg    <= rd_issue_reg;
            clr_done_reg   <= (state_reg == CLR);
            err_reg        <= err_reg | ((|rd_pend_reg) & ~mem_ready);
        end
    end

    assign gnt_a      = gnt_reg[0];
    assign gnt_b      = gnt_reg[1];
    assign rvalid_a   = rvalid_v[0];
    assign rvalid_b   = rvalid_v[1];
    assign rdata_a    = rdata_v[0];
    assign rdata_b    = rdata_v[1];
    assign clr_done   = clr_done_reg;
    assign mem_valid  = mem_valid_reg;
    assign mem_we     = mem_we_reg;
    assign mem_re     = mem_re_reg;
    assign mem_w_addr = mem_w_addr_reg;
    assign mem_r_addr = mem_r_addr_reg;
    assign mem_w_data = mem_w_data_reg;
    assign err        = err_reg;

endmodule

// File: doc/dp_mem_arbiter.md
# dp_mem_arbiter

Two-client arbiter and sequencer for `dp_memory`, the team's dual-port memory. It takes independent single-word read/write requests from client A and client B and issues legal memory commands with round-robin fairness. When one client writes and the other reads different addresses, it merges them into one `we=1,re=1` cycle. It also supplies an explicit whole-memory clear and routes read data back to the issuing client.

## Interface
- `DATA_SIZE`, 32, data width; must match the memory.
- `ADDR_WIDTH`, 4, address width; must match the memory.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_a`, `req_b`  in  1  request; held until the matching `gnt_*` is seen.
- `we_a`, `we_b`  in  1  1 = write, 0 = read; valid with `req_*`.
- `addr_a`, `addr_b`  in  ADDR_WIDTH  word address.
- `wdata_a`, `wdata_b`  in  DATA_SIZE  write data.
- `gnt_a`, `gnt_b`  out  1  one-cycle pulse: request accepted.
- `rvalid_a`, `rvalid_b`  out  1  one-cycle pulse: read data present.
- `rdata_a`, `rdata_b`  out  DATA_SIZE  equals `mem_r_data` while the matching `rvalid_*` is 1, else 0.
- `clr_req`  in  1  level; request a full-memory clear.
- `clr_done`  out  1  one-cycle pulse: clear completed.
- `mem_valid`, `mem_we`, `mem_re`  out  1  memory command.
- `mem_w_addr`, `mem_r_addr`  out  ADDR_WIDTH  memory addresses.
- `mem_w_data`  out  DATA_SIZE  memory write data.
- `mem_r_data`  in  DATA_SIZE  memory read data.
- `mem_ready`  in  1  memory ready, one cycle after `mem_valid`.
- `err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- **Decision cycle.** Each cycle the arbiter considers eligible requests. A client is not eligible in the cycle its `gnt_*` is high. The registered command, `gnt_*` and the read-pending flags are updated at the clock edge.
- **Priority order:**
  - `clr_req` first: issue `mem_valid=1,mem_we=0,mem_re=0`, which clears the memory. No grants that cycle; `clr_req` stays ineligible while `clr_done` is high.
  - Merge: one eligible write plus one eligible read with `addr_a != addr_b`. Grant both and issue `we=1,re=1`. The round-robin pointer is unchanged.
  - Otherwise, one client wins by round-robin. The pointer holds the last sole-granted client and resets to B, so A wins the first tie. A lone requester always wins.
  - Same-address write/read is never merged; it is serialised by round-robin.
- **Legal commands.** `mem_valid` is never 1 with `we=re=0` except for a clear command. Unused address/data outputs hold 0.
- **State machine:**
  - `IDLE`: no command issued.
  - `CMD`: a command was issued last edge.
  - `CLR`: a clear was issued last edge.
  - Transitions: any state → `CLR` on eligible `clr_req`; → `CMD` on any grant; else → `IDLE`.
- **Read return.**
  - `rd_pend_a/b` set when a read is issued.
  - `rvalid_x = rd_pend_x & mem_ready`.
  - `err` sets if `rd_pend_x` is 1 while `mem_ready` is 0.

## Timing
- Reset values: all outputs 0, state `IDLE`, pointer = B, pending flags cleared.
- A reset mid-operation drops in-flight reads: no `rvalid_*` follows it.
- Request with `req` high in cycle 0:
  - cycle 1: `gnt_*`, `mem_valid` and the command.
  - cycle 2: `mem_ready`, and `rvalid_*` with data for reads.
  - Read latency is 2 cycles.
- Throughput:
  - One command per cycle overall.
  - One grant per 2 cycles for a single client, because a client is ineligible in its grant cycle.
  - Alternating clients sustain a command every cycle.
- Clear: clear command in cycle 1, `clr_done` in cycle 2. A read issued in the cycle before the clear still returns its pre-clear data.
- Merged cycle with different addresses: the read returns the old contents of `mem_r_addr`.

## Structure
- Package `dp_mem_pkg` holds:
  - `DATA_SIZE` and `ADDR_WIDTH` defaults.
  - Command enum `CMD_NONE`, `CMD_WR`, `CMD_RD`, `CMD_WRRD`, `CMD_CLR`.
  - State enum `IDLE`, `CMD`, `CLR`.
- Sub-module `rr_arb2`: two-way round-robin picker with the pointer register and an update-enable. `dp_mem_arbiter` instantiates it once.

## Test plan
- **Write then read, A only.** A writes 0xDEADBEEF to address 3, then reads address 3. Expect `gnt_a` in cycle 1; the read returns `rdata_a`=0xDEADBEEF 2 cycles after its request. `rvalid_b` stays 0 throughout.
- **Merge.** Memory address 9 preloaded with 0x11. In one cycle, A writes 0x5555 to address 5 and B reads address 9. Expect both grants in the same cycle, `mem_we=mem_re=1`, and `rdata_b`=0x11.
- **Same-address collision.** Memory address 7 holds 0x0 and the pointer is B. A writes 0xAAAA to address 7 while B reads address 7. Expect A granted first, B granted one cycle later, and `rdata_b`=0xAAAA.
- **Fairness.** A and B both hold read requests continuously for 8 grants. Expect grants to alternate A,B,A,B…. No `mem_valid` with `we=re=0` appears at any time.
- **Clear.**
  - `clr_req` is asserted while B's read is pending. Expect B's pending read to return its pre-clear data.
  - Expect the clear command in the next cycle and `clr_done` one cycle after that.
  - Any later read returns 0.
- **Reset mid-read.** Assert `rst`=0 in the cycle after `gnt_a` for a read. Expect all outputs 0 immediately, no `rvalid_a`, and after release A wins the first tie.
